// File: rtl/mdu_ctrl.sv
// Issue controller for the iterative multiply/divide unit: 2-entry request FIFO plus IDLE/LAUNCH/WAIT sequencer.
// Optional flush support is compiled in with the MDU_FLUSH_EN macro; without it the flush port is ignored.
module mdu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        hilo_rd,
   output logic        stall,
   input  logic        flush,
   output logic        mdu_start,
   output logic [2:0]  mdu_mdop,
   output logic [31:0] mdu_op1,
   output logic [31:0] mdu_op2,
   output logic [1:0]  mdu_wen,
   input  logic        mdu_busy,
   output logic [1:0]  pending,
   output logic [1:0]  state_dbg
);

   // Handshake: a request is taken on a clk edge where req_valid && req_ready; req_ready depends only on occupancy.
   typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2} state_t;

   localparam logic [2:0] OP_MTLO = 3'd4;
   localparam logic [2:0] OP_MTHI = 3'd5;

   state_t      state, state_nxt;
   logic [2:0]  fifo_op [2];
   logic [31:0] fifo_a  [2];
   logic [31:0] fifo_b  [2];
   logic        wr_ptr, rd_ptr;
   logic [1:0]  count;
   logic        flush_act, push, pop, op_legal;
   logic [2:0]  head_op;
   logic [31:0] head_a, head_b;

`ifdef MDU_FLUSH_EN
   assign flush_act = flush;
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign flush_act    = 1'b0;
`endif

   assign req_ready = (count != 2'd2);
   assign op_legal  = (req_op <= OP_MTHI);
   // Illegal opcodes still complete the handshake but are never stored.
   assign push      = req_valid && req_ready && op_legal && !flush_act;
   assign head_op   = fifo_op[rd_ptr];
   assign head_a    = fifo_a[rd_ptr];
   assign head_b    = fifo_b[rd_ptr];
   assign pending   = count;
   assign state_dbg = state;
   assign stall     = hilo_rd && ((count != 2'd0) || (state != IDLE));

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush_act) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr] <= req_op;
         fifo_a[wr_ptr]  <= req_a;
         fifo_b[wr_ptr]  <= req_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      mdu_start = 1'b0;
      mdu_wen   = 2'b00;
      mdu_mdop  = 3'd0;
      mdu_op1   = 32'd0;
      mdu_op2   = 32'd0;
      case (state)
         IDLE: begin
            if ((count != 2'd0) && !mdu_busy && !flush_act) begin
               pop = 1'b1;
               if (head_op == OP_MTLO) begin
                  mdu_wen = 2'b01;
                  mdu_op1 = head_a;
               end else if (head_op == OP_MTHI) begin
                  mdu_wen = 2'b10;
                  mdu_op1 = head_a;
               end else begin
                  mdu_start = 1'b1;
                  mdu_mdop  = head_op;
                  mdu_op1   = head_a;
                  mdu_op2   = head_b;
                  state_nxt = LAUNCH;
               end
            end
         end
         // The unit raises busy one cycle after start, so LAUNCH never looks at it.
         LAUNCH:  state_nxt = WAIT;
         WAIT:    if (!mdu_busy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: behavioural iterative unit, issue scoreboard, vector table and corner sequences.
`timescale 1ns/1ps
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic        hilo_rd = 1'b0;
   logic        stall;
   logic        flush = 1'b0;
   logic        mdu_start;
   logic [2:0]  mdu_mdop;
   logic [31:0] mdu_op1, mdu_op2;
   logic [1:0]  mdu_wen;
   logic        mdu_busy;
   logic [1:0]  pending;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;
   logic [69:0] exp_q[$];

   always #5 clk = ~clk;

   mdu_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .hilo_rd(hilo_rd), .stall(stall), .flush(flush),
      .mdu_start(mdu_start), .mdu_mdop(mdu_mdop), .mdu_op1(mdu_op1), .mdu_op2(mdu_op2),
      .mdu_wen(mdu_wen), .mdu_busy(mdu_busy), .pending(pending), .state_dbg(state_dbg)
   );

   // Behavioural multiply/divide unit: busy for busy_len cycles starting the cycle after start.
   int unsigned busy_len = 4;
   int unsigned busy_cnt;
   logic        unit_hold = 1'b0;
   logic [31:0] unit_hi, unit_lo, res_hi, res_lo;

   assign mdu_busy = (busy_cnt != 0) || unit_hold;

   function automatic logic [63:0] unit_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      r = '0;
      case (op)
         3'd0: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         3'd1: r = {32'd0, a} * {32'd0, b};
         3'd2: if (b != 0) r = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
         3'd3: if (b != 0) r = {a % b, a / b};
         default: r = '0;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         busy_cnt <= 0;
         unit_hi  <= 32'd0;
         unit_lo  <= 32'd0;
         res_hi   <= 32'd0;
         res_lo   <= 32'd0;
      end else begin
         if (mdu_start) begin
            busy_cnt         <= busy_len;
            {res_hi, res_lo} <= unit_calc(mdu_mdop, mdu_op1, mdu_op2);
         end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
               unit_hi <= res_hi;
               unit_lo <= res_lo;
            end
         end
         if (mdu_wen[0]) unit_lo <= mdu_op1;
         if (mdu_wen[1]) unit_hi <= mdu_op1;
      end
   end

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [69:0] tag(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 3'd4)      return {1'b0, 2'b01, 3'd0, a, 32'd0};
      else if (op == 3'd5) return {1'b0, 2'b10, 3'd0, a, 32'd0};
      else                 return {1'b1, 2'b00, op, a, b};
   endfunction

   // Issue monitor: every start/wen pulse must match the next expected issue in order.
   always @(negedge clk) begin
      if (!rst) begin
         if (mdu_start || (mdu_wen != 2'b00)) begin
            check("start_wen_exclusive", {71'd0, mdu_start && (mdu_wen != 2'b00)}, 72'd0);
            if (exp_q.size() == 0)
               check("unexpected_issue", {2'b0, mdu_start, mdu_wen, mdu_mdop, mdu_op1, mdu_op2}, 72'd0);
            else
               check("issue_order", {2'b0, mdu_start, mdu_wen, mdu_mdop, mdu_op1, mdu_op2}, {2'b0, exp_q.pop_front()});
         end else begin
            check("idle_zero", {mdu_mdop, mdu_op1, mdu_op2}, 72'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_issue);
      if (expect_issue) exp_q.push_back(tag(op, a, b));
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      tick();
      req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (!(state_dbg == 2'd0 && pending == 2'd0 && !mdu_busy) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("wait_idle_timeout", 72'd1, 72'd0);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          busy;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int n;
      vecs[0] = '{3'd0, 32'd7,          32'hFFFFFFFD, 5, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1] = '{3'd1, 32'hFFFFFFFF,   32'd2,        3, 32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{3'd2, 32'hFFFFFF9C,   32'd7,        8, 32'hFFFFFFFE, 32'hFFFFFFF2};
      vecs[3] = '{3'd3, 32'd100,        32'd7,        1, 32'h00000002, 32'h0000000E};
      vecs[4] = '{3'd4, 32'h12345678,   32'd9,        2, 32'h00000002, 32'h12345678};
      vecs[5] = '{3'd5, 32'hCAFEBABE,   32'd9,        2, 32'hCAFEBABE, 32'h12345678};
      vecs[6] = '{3'd6, 32'd1,          32'd1,        2, 32'hCAFEBABE, 32'h12345678};
      vecs[7] = '{3'd7, 32'd5,          32'd5,        2, 32'hCAFEBABE, 32'h12345678};
      vecs[8] = '{3'd0, 32'h80000000,   32'h80000000, 2, 32'h40000000, 32'h00000000};
      vecs[9] = '{3'd3, 32'hFFFFFFFF,   32'h10,       2, 32'h0000000F, 32'h0FFFFFFF};

      // Reset state, with hilo_rd high to show stall stays low.
      hilo_rd = 1'b1;
      tick(); tick();
      check("rst_pending", pending, 0);
      check("rst_ready", req_ready, 1);
      check("rst_start", mdu_start, 0);
      check("rst_wen", mdu_wen, 0);
      check("rst_stall", stall, 0);
      check("rst_state", state_dbg, 0);
      rst = 1'b0; hilo_rd = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         busy_len = vecs[i].busy;
         check($sformatf("v%0d_ready", i), req_ready, 1);
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].op <= 3'd5);
         if (vecs[i].op <= 3'd3) begin
            check($sformatf("v%0d_start", i), mdu_start, 1);
            check($sformatf("v%0d_pending", i), pending, 1);
         end else if (vecs[i].op <= 3'd5) begin
            check($sformatf("v%0d_wen", i), mdu_wen, (vecs[i].op == 3'd4) ? 2'b01 : 2'b10);
            check($sformatf("v%0d_nostart", i), mdu_start, 0);
         end else begin
            check($sformatf("v%0d_pending", i), pending, 0);
            check($sformatf("v%0d_nostart", i), mdu_start, 0);
            check($sformatf("v%0d_nowen", i), mdu_wen, 0);
         end
         wait_idle(n);
         if (vecs[i].op <= 3'd3) check($sformatf("v%0d_latency", i), n, vecs[i].busy + 2);
         check($sformatf("v%0d_hi", i), unit_hi, vecs[i].exp_hi);
         check($sformatf("v%0d_lo", i), unit_lo, vecs[i].exp_lo);
         check($sformatf("v%0d_state", i), state_dbg, 0);
      end

      // DIVU then MFLO: stall from the cycle after accept through the first non-busy cycle.
      busy_len = 4; hilo_rd = 1'b1;
      check("mflo_stall_pre", stall, 0);
      send(3'd3, 32'd100, 32'd7, 1'b1);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("mflo_stall_%0d", k), stall, 1);
         if (k == 4) check("mflo_busy_last", mdu_busy, 1);
         if (k == 5) check("mflo_busy_fall", mdu_busy, 0);
         tick();
      end
      check("mflo_stall_end", stall, 0);
      check("mflo_lo", unit_lo, 32'd14);
      check("mflo_hi", unit_hi, 32'd2);
      hilo_rd = 1'b0;

      // Back-to-back MULTU, MTHI, DIV with the unit held busy to fill the FIFO.
      busy_len = 3; unit_hold = 1'b1;
      send(3'd1, 32'd3, 32'd5, 1'b1);
      check("b2b_pending1", pending, 1);
      send(3'd5, 32'h55, 32'd0, 1'b1);
      check("b2b_pending2", pending, 2);
      check("b2b_ready0", req_ready, 0);
      exp_q.push_back(tag(3'd2, 32'd50, 32'd5));
      req_valid = 1'b1; req_op = 3'd2; req_a = 32'd50; req_b = 32'd5;
      tick();
      check("b2b_blocked", pending, 2);
      unit_hold = 1'b0;
      #1;
      check("b2b_start_multu", {mdu_start, mdu_mdop}, {1'b1, 3'd1});
      tick();
      check("b2b_ready1", req_ready, 1);
      check("b2b_pending_pop", pending, 1);
      tick();
      req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
      check("b2b_pending_div", pending, 2);
      n = 0;
      while (mdu_wen == 2'b00 && n < 20) begin tick(); n++; end
      check("b2b_mthi_delay", n, 3);
      check("b2b_mthi", {mdu_wen, mdu_op1}, {2'b10, 32'h55});
      check("b2b_mthi_busy", mdu_busy, 0);
      check("b2b_mthi_state", state_dbg, 0);
      tick();
      check("b2b_div_start", {mdu_start, mdu_mdop}, {1'b1, 3'd2});
      wait_idle(n);
      check("b2b_hi", unit_hi, 32'd0);
      check("b2b_lo", unit_lo, 32'd10);

      // Accept while stalled, then reset mid-WAIT; the queued MTLO must never issue.
      busy_len = 10; hilo_rd = 1'b1;
      send(3'd0, 32'd9, 32'd9, 1'b1);
      tick(); tick();
      check("rstw_state_wait", state_dbg, 2);
      check("rstw_stall", stall, 1);
      check("rstw_ready", req_ready, 1);
      send(3'd4, 32'hAA, 32'd0, 1'b0);
      check("rstw_accept_stalled", pending, 1);
      rst = 1'b1;
      tick();
      check("rstw_pending", pending, 0);
      check("rstw_ready_after", req_ready, 1);
      check("rstw_outs", {mdu_start, mdu_wen, mdu_mdop, mdu_op1, mdu_op2}, 72'd0);
      check("rstw_stall_after", stall, 0);
      check("rstw_state", state_dbg, 0);
      rst = 1'b0; hilo_rd = 1'b0;
      tick();
      busy_len = 3;
      send(3'd0, 32'd3, 32'd4, 1'b1);
      check("rstw_new_start", mdu_start, 1);
      wait_idle(n);
      check("rstw_new_lat", n, 5);
      check("rstw_new_lo", unit_lo, 32'd12);
      check("rstw_new_hi", unit_hi, 32'd0);

`ifdef MDU_FLUSH_EN
      busy_len = 6;
      send(3'd2, 32'd50, 32'd5, 1'b1);
      tick(); tick();
      send(3'd4, 32'd1, 32'd0, 1'b0);
      send(3'd0, 32'd2, 32'd2, 1'b0);
      check("fl_pending2", pending, 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_pending0", pending, 0);
      check("fl_state_wait", state_dbg, 2);
      wait_idle(n);
      check("fl_div_lo", unit_lo, 32'd10);
      check("fl_div_hi", unit_hi, 32'd0);
      flush = 1'b1;
      send(3'd5, 32'h33, 32'd0, 1'b0);
      flush = 1'b0;
      check("fl_push_dropped", pending, 0);
      send(3'd4, 32'h44, 32'd0, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_issue_blocked", pending, 0);
      check("fl_lo_kept", unit_lo, 32'd10);
`else
      flush = 1'b1;
      send(3'd4, 32'h99, 32'd0, 1'b1);
      check("fl_ignored_pending", pending, 1);
      tick();
      flush = 1'b0;
      check("fl_ignored_lo", unit_lo, 32'h99);
`endif

      tick(); tick(); tick();
      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
